rv523_serial_regfile: RTL
=========================

Name: rv523_serial_regfile

Overview:
Parametrised digit-serial integer register file for the RV523 discrete-transistor core. It streams two source registers out LSB-first, DIGIT bits per cycle, while writing a destination register digit by digit in the same pass. This keeps the datapath narrow, which saves MOSFET count. It sits between the decode sequencer and the serial ALU and replaces the fixed-width bit-serial prototype with a version generalised in width, depth and digit size, adding request handshake and stall.

Parameters:
XLEN, 32, register width in bits.
NREGS, 32, number of architectural registers; power of two, at least 2.
DIGIT, 1, bits transferred per cycle; must divide XLEN. BEATS = XLEN/DIGIT.
ZERO_REG, 1, when 1 register 0 reads all-zero and ignores writes.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  request to start one streaming pass.
req_ready  out  1  block can accept a request.
req_rs1  in  clog2(NREGS)  source 1 index.
req_rs2  in  clog2(NREGS)  source 2 index.
req_rd  in  clog2(NREGS)  destination index.
req_we  in  1  write destination during this pass.
hold  in  1  stall the current beat.
beat_valid  out  1  rs1_digit/rs2_digit valid and wr_digit sampled this cycle.
rs1_digit  out  DIGIT  current digit of rs1, LSB-first.
rs2_digit  out  DIGIT  current digit of rs2, LSB-first.
wr_digit  in  DIGIT  digit to write into rd at the current beat.
last  out  1  current beat is beat BEATS-1.
done  out  1  one-cycle pulse after pass completes.

Behaviour:
- Reset values: FSM to IDLE, beat counter 0, captured indices 0, done=0, beat_valid=0, last=0, req_ready=1 after reset deasserts. Storage array is NOT reset, to save transistors; its contents after reset are undefined except register 0 when ZERO_REG=1.
- The FSM has three states: IDLE, STREAM, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid=1, capture rs1/rs2/rd/we, clear the counter and move to STREAM next cycle.
  - First digit appears one cycle after acceptance.
- STREAM:
  - beat_valid = ~hold. rs1_digit/rs2_digit are combinational from the captured index and counter (bits [cnt*DIGIT +: DIGIT]).
  - When hold=0: if we=1 and not (ZERO_REG and rd==0), write wr_digit into rd bits [cnt*DIGIT +: DIGIT] at the clock edge, then increment cnt.
  - When hold=1: counter frozen, no write, outputs still driven with the same digit.
  - last = (cnt==BEATS-1) & beat_valid.
  - The accepted beat with cnt==BEATS-1 moves to DONE.
- DONE:
  - done=1 for exactly one cycle, req_ready=0, then return to IDLE.
  - Minimum pass latency is BEATS+2 cycles from acceptance to the next possible acceptance.
- Read-before-write: if rd equals rs1 or rs2, each streamed digit is the value before this pass, because digit k is read in the same beat in which it is overwritten and lower digits are never re-read.
- ZERO_REG=1:
  - Index 0 reads zero regardless of storage.
  - Write to rd=0 is suppressed, but the pass still runs full length.
- req_ready=0 in STREAM and DONE; req_valid there is ignored, not queued.
- BEATS=1 (DIGIT=XLEN):
  - STREAM lasts one accepted beat.
  - last=1 on that beat.
- Reset mid-pass: the next cycle is IDLE; a partially written rd keeps digits already written, the rest is unchanged.
- Counter width max(1, clog2(BEATS)); no wrap inside a pass.

Decomposition:
- Shared package rv523_pkg:
  - state enum (IDLE, STREAM, DONE);
  - default XLEN/NREGS constants;
  - clog2 helper function.
- One natural sub-module, rv523_serial_word:
  - one XLEN-bit register with digit-indexed write enable and digit read mux;
  - instantiated NREGS times, or NREGS-1 when ZERO_REG=1.

Test Plan:
- XLEN=32, DIGIT=1: write pass rd=5, we=1, wr_digit stream of 0xA5A5_0F0F LSB-first. A second pass with rs1=5 outputs the same 32 digits, last on beat 31, done one cycle later.
- ZERO_REG=1: pass with rd=0, we=1, all-ones data. A subsequent pass with rs1=0, rs2=0 streams all zeros.
- DIGIT=8: x3=0x11223344 and x4=0x55667788 preloaded; pass rs1=3, rs2=4, rd=3 writing 0xDEADBEEF. rs1 digits are 0x44,0x33,0x22,0x11 (old value); a later read of x3 gives 0xDEADBEEF.
- hold asserted on beats 2-4 of a DIGIT=4 pass. Digit 2 is held stable, no extra write occurs, the pass takes 3 extra cycles, and the final value is correct.
- rst asserted at beat 10 of a DIGIT=1 write of 0xFFFFFFFF to a register holding 0. The next cycle has req_ready=1; the register then reads 0x000003FF.
- req_valid held high through STREAM and DONE: exactly one pass per acceptance, done pulses once, and the next acceptance happens only in IDLE.

Source files
------------

// File: rtl/rv523_pkg.sv
// Shared types and constants for the RV523 digit-serial register file.
package rv523_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  // Ceiling log2, usable in parameter and port-width expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rv523_serial_word.sv
// One XLEN-bit architectural register, written and read one digit at a time.
module rv523_serial_word
  import rv523_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DIGIT = 1,
  parameter int CW    = 5
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [CW-1:0]    sel,
  input  logic [DIGIT-1:0] wr_digit,
  output logic [DIGIT-1:0] rd_digit
);

  logic [XLEN-1:0] word;
  int              off;

  assign off      = int'(sel) * DIGIT;
  assign rd_digit = word[off +: DIGIT];

  // Storage has no reset; only the selected digit is overwritten.
  always_ff @(posedge clk) begin
    if (wr_en) word[off +: DIGIT] <= wr_digit;
  end

endmodule

// File: rtl/rv523_serial_regfile.sv
// Digit-serial register file: streams rs1/rs2 LSB-first while writing rd
// digit by digit in the same pass, with request handshake and beat stall.
module rv523_serial_regfile
  import rv523_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int DIGIT    = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [clog2(NREGS)-1:0] req_rs1,
  input  logic [clog2(NREGS)-1:0] req_rs2,
  input  logic [clog2(NREGS)-1:0] req_rd,
  input  logic                    req_we,
  input  logic                    hold,
  output logic                    beat_valid,
  output logic [DIGIT-1:0]        rs1_digit,
  output logic [DIGIT-1:0]        rs2_digit,
  input  logic [DIGIT-1:0]        wr_digit,
  output logic                    last,
  output logic                    done
);

  localparam int AW    = clog2(NREGS);
  localparam int BEATS = XLEN / DIGIT;
  localparam int CW    = (clog2(BEATS) > 1) ? clog2(BEATS) : 1;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    rs1_q;
  logic [AW-1:0]    rs2_q;
  logic [AW-1:0]    rd_q;
  logic             we_q;
  logic             cnt_last;
  logic             beat_ok;
  logic             wr_hit;
  logic [DIGIT-1:0] digs [NREGS];

  assign beat_valid = (state == STREAM) & ~hold;
  assign cnt_last   = (cnt == CW'(BEATS - 1));
  assign last       = cnt_last & beat_valid;
  // A beat landing on a reset edge must not commit its digit.
  assign beat_ok    = beat_valid & ~rst;
  assign wr_hit     = beat_ok & we_q & ~((ZERO_REG != 0) && (rd_q == '0));

  // Reading happens combinationally in the same beat that overwrites the
  // digit, so a pass with rd == rs1/rs2 always streams the old value.
  assign rs1_digit = digs[rs1_q];
  assign rs2_digit = digs[rs2_q];

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
      assign digs[i] = '0;
    end else begin : g_word
      rv523_serial_word #(
        .XLEN (XLEN),
        .DIGIT(DIGIT),
        .CW   (CW)
      ) u_word (
        .clk     (clk),
        .wr_en   (wr_hit && (rd_q == AW'(i))),
        .sel     (cnt),
        .wr_digit(wr_digit),
        .rd_digit(digs[i])
      );
    end
  end

  // Pass sequencer: accept in IDLE, walk the beats in STREAM, pulse done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      we_q      <= 1'b0;
      done      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (req_valid) begin
            rs1_q     <= req_rs1;
            rs2_q     <= req_rs2;
            rd_q      <= req_rd;
            we_q      <= req_we;
            cnt       <= '0;
            req_ready <= 1'b0;
            state     <= STREAM;
          end
        end
        STREAM: begin
          if (!hold) begin
            if (cnt_last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        DONE: begin
          done      <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          done      <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
